// File: rtl/hft_pkg.sv
// rtl/hft_pkg.sv - shared widths, arbiter state type and index helper for the feed arbiter
package hft_pkg;

    localparam int AXI_DATA_W_DEF = 64;
    localparam int AXI_KEEP_W_DEF = AXI_DATA_W_DEF / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Next channel index with wrap, used to advance the round-robin pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first-requester search from a start pointer with wrap; one-hot grant plus index
module rr_pick #(
    parameter int CH_N  = 2,
    parameter int RR_EN = 1,
    localparam int IDX_W = $clog2(CH_N)
) (
    input  logic [CH_N-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [CH_N-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : pick
        int base;
        int c;
        logic [IDX_W-1:0] cidx;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        c    = 0;
        cidx = '0;
        // Fixed priority is simply a search that always starts at channel 0.
        base = (RR_EN != 0) ? int'(start) : 0;
        for (int i = 0; i < CH_N; i++) begin
            c    = (base + i) % CH_N;
            cidx = IDX_W'(c);
            if (!any && req[cidx]) begin
                any       = 1'b1;
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/udp_feed_arb.sv
// rtl/udp_feed_arb.sv - packet-granular N:1 AXI-stream arbiter with registered output and stall watchdog
module udp_feed_arb
    import hft_pkg::*;
#(
    parameter int AXI_DATA_W = AXI_DATA_W_DEF,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int CH_N       = 2,
    parameter int RR_EN      = 1,
    parameter int TIMEOUT    = 256,
    localparam int IDX_W     = $clog2(CH_N)
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [CH_N-1:0]            s_axis_tvalid,
    input  logic [CH_N*AXI_DATA_W-1:0] s_axis_tdata,
    input  logic [CH_N*AXI_KEEP_W-1:0] s_axis_tkeep,
    input  logic [CH_N-1:0]            s_axis_tlast,
    input  logic [CH_N-1:0]            s_axis_tuser,
    output logic [CH_N-1:0]            s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [AXI_DATA_W-1:0]      m_axis_tdata,
    output logic [AXI_KEEP_W-1:0]      m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    input  logic                       m_axis_tready,
    output logic [IDX_W-1:0]           grant_o,
    output logic                       abort_o
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [CH_N-1:0]  drain, drain_nxt;
    logic [WD_W-1:0]  wdog, wdog_nxt;

    logic             slot_free;
    logic [CH_N-1:0]  elig;
    logic [CH_N-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] sel;
    logic             load;
    logic             abort_fire;
    logic             wd_expired;
    logic [CH_N-1:0]  ready;

    assign slot_free  = ~m_axis_tvalid | m_axis_tready;
    assign elig       = s_axis_tvalid & ~drain;
    assign wd_expired = (TIMEOUT > 0) && (wdog >= WD_W'(TIMEOUT - 1));

    rr_pick #(
        .CH_N  (CH_N),
        .RR_EN (RR_EN)
    ) u_pick (
        .req   (elig),
        .start (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_o;
        wdog_nxt   = wdog;
        load       = 1'b0;
        abort_fire = 1'b0;
        sel        = grant_o;
        ready      = '0;
        case (state)
            IDLE: begin
                wdog_nxt = '0;
                if (slot_free && pick_any) begin
                    ready     = pick_gnt;
                    load      = 1'b1;
                    sel       = pick_idx;
                    grant_nxt = pick_idx;
                    if (s_axis_tlast[pick_idx]) begin
                        rr_ptr_nxt = IDX_W'(wrap_inc(int'(pick_idx), CH_N));
                    end else begin
                        state_nxt = LOCK;
                    end
                end
            end
            LOCK: begin
                ready[grant_o] = slot_free;
                if (s_axis_tvalid[grant_o]) begin
                    // A present beat means the source is alive even if downstream stalls it.
                    wdog_nxt = '0;
                    if (slot_free) begin
                        load = 1'b1;
                        if (s_axis_tlast[grant_o]) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = IDX_W'(wrap_inc(int'(grant_o), CH_N));
                        end
                    end
                end else if (TIMEOUT > 0) begin
                    if (wd_expired && slot_free) begin
                        abort_fire = 1'b1;
                        state_nxt  = IDLE;
                        rr_ptr_nxt = IDX_W'(wrap_inc(int'(grant_o), CH_N));
                        wdog_nxt   = '0;
                    end else if (wdog != WD_W'(TIMEOUT)) begin
                        wdog_nxt = wdog + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Draining channels swallow beats until their tlast, independent of arbitration.
        drain_nxt = drain & ~(s_axis_tvalid & s_axis_tlast);
        if (abort_fire) begin
            drain_nxt[grant_o] = 1'b1;
        end
        ready = ready | drain;
    end

    assign s_axis_tready = nreset ? ready : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            drain  <= '0;
            wdog   <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            drain  <= drain_nxt;
            wdog   <= wdog_nxt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            grant_o       <= '0;
            abort_o       <= 1'b0;
        end else begin
            grant_o <= grant_nxt;
            abort_o <= abort_fire;
            if (slot_free) begin
                m_axis_tvalid <= load | abort_fire;
                if (abort_fire) begin
                    m_axis_tdata <= '0;
                    m_axis_tkeep <= '0;
                    m_axis_tlast <= 1'b1;
                    m_axis_tuser <= 1'b1;
                end else if (load) begin
                    m_axis_tdata <= s_axis_tdata[int'(sel)*AXI_DATA_W +: AXI_DATA_W];
                    m_axis_tkeep <= s_axis_tkeep[int'(sel)*AXI_KEEP_W +: AXI_KEEP_W];
                    m_axis_tlast <= s_axis_tlast[sel];
                    m_axis_tuser <= s_axis_tuser[sel];
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_feed_arb.sv
// tb/tb_udp_feed_arb.sv - directed self-checking bench for udp_feed_arb (round-robin, fixed priority, watchdog)
module tb_udp_feed_arb;

    localparam logic [9:0] KLU_MID   = 10'h3FC;
    localparam logic [9:0] KLU_LAST  = 10'h3FE;
    localparam logic [9:0] KLU_ABORT = 10'h003;

    logic         clk;
    logic         nreset;
    logic [1:0]   s_axis_tvalid;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic [1:0]   s_axis_tlast;
    logic [1:0]   s_axis_tuser;
    logic [1:0]   s_axis_tready;
    logic         m_axis_tvalid;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic         m_axis_tready;
    logic         grant_o;
    logic         abort_o;

    logic [1:0]   fp_tvalid;
    logic [127:0] fp_tdata;
    logic [15:0]  fp_tkeep;
    logic [1:0]   fp_tlast;
    logic [1:0]   fp_tuser;
    logic [1:0]   fp_tready;
    logic         fp_m_tvalid;
    logic [63:0]  fp_m_tdata;
    logic [7:0]   fp_m_tkeep;
    logic         fp_m_tlast;
    logic         fp_m_tuser;
    logic         fp_m_tready;
    logic         fp_grant;
    logic         fp_abort;

    assign fp_tvalid   = 2'b11;
    assign fp_tdata    = {64'h66, 64'h55};
    assign fp_tkeep    = 16'hFFFF;
    assign fp_tlast    = 2'b11;
    assign fp_tuser    = 2'b00;
    assign fp_m_tready = 1'b1;

    udp_feed_arb #(.AXI_DATA_W(64), .CH_N(2), .RR_EN(1), .TIMEOUT(4)) dut (
        .clk(clk), .nreset(nreset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant_o(grant_o), .abort_o(abort_o)
    );

    udp_feed_arb #(.AXI_DATA_W(64), .CH_N(2), .RR_EN(0), .TIMEOUT(4)) dut_fp (
        .clk(clk), .nreset(nreset),
        .s_axis_tvalid(fp_tvalid), .s_axis_tdata(fp_tdata), .s_axis_tkeep(fp_tkeep),
        .s_axis_tlast(fp_tlast), .s_axis_tuser(fp_tuser), .s_axis_tready(fp_tready),
        .m_axis_tvalid(fp_m_tvalid), .m_axis_tdata(fp_m_tdata), .m_axis_tkeep(fp_m_tkeep),
        .m_axis_tlast(fp_m_tlast), .m_axis_tuser(fp_m_tuser), .m_axis_tready(fp_m_tready),
        .grant_o(fp_grant), .abort_o(fp_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] smem [2][8];
    logic        slast[2][8];
    int          slen [2];
    int          sptr [2];
    bit          sen  [2];
    bit          mr_mode;

    logic [63:0] od[$];
    logic [9:0]  ok[$];
    int          oc[$];
    logic [1:0]  rdy_hist[64];
    int          cycn;
    int          hold_err;
    int          abort_cnt;
    bit          stalled_prev;
    logic [63:0] stalled_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_beat(input string tag, input int i, input logic [63:0] d, input logic [9:0] klu);
        logic [63:0] dv;
        logic [9:0]  kv;
        dv = (i < od.size()) ? od[i] : 'x;
        kv = (i < ok.size()) ? ok[i] : 'x;
        check($sformatf("%s_b%0d_data", tag, i), dv, d);
        check($sformatf("%s_b%0d_klu", tag, i), {54'b0, kv}, {54'b0, klu});
    endtask

    task automatic load(input int ch, input int i, input logic [63:0] d, input logic l);
        smem[ch][i]  = d;
        slast[ch][i] = l;
        if (i + 1 > slen[ch]) slen[ch] = i + 1;
    endtask

    // One clock of stimulus: drive sources, observe at negedge, advance on handshake.
    task automatic cyc();
        logic [1:0] vld;
        logic [1:0] rdy;
        int p;
        for (int c = 0; c < 2; c++) begin
            p = (sptr[c] < 8) ? sptr[c] : 7;
            s_axis_tvalid[c]          = sen[c] && (sptr[c] < slen[c]);
            s_axis_tdata[c*64 +: 64]  = s_axis_tvalid[c] ? smem[c][p] : 64'h0;
            s_axis_tlast[c]           = s_axis_tvalid[c] ? slast[c][p] : 1'b0;
            s_axis_tkeep[c*8 +: 8]    = 8'hFF;
            s_axis_tuser[c]           = 1'b0;
        end
        if (mr_mode) m_axis_tready = ~m_axis_tready;
        @(negedge clk);
        if (cycn < 64) rdy_hist[cycn] = s_axis_tready;
        if (stalled_prev && (!m_axis_tvalid || m_axis_tdata !== stalled_data)) hold_err++;
        stalled_prev = m_axis_tvalid && !m_axis_tready;
        stalled_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            od.push_back(m_axis_tdata);
            ok.push_back({m_axis_tkeep, m_axis_tlast, m_axis_tuser});
            oc.push_back(cycn);
        end
        if (abort_o) abort_cnt++;
        vld = s_axis_tvalid;
        rdy = s_axis_tready;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) if (vld[c] && rdy[c]) sptr[c]++;
        cycn++;
    endtask

    task automatic do_reset();
        nreset        = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        mr_mode       = 1'b0;
        for (int c = 0; c < 2; c++) begin
            slen[c] = 0;
            sptr[c] = 0;
            sen[c]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        od.delete();
        ok.delete();
        oc.delete();
        cycn         = 0;
        hold_err     = 0;
        abort_cnt    = 0;
        stalled_prev = 1'b0;
        stalled_data = '0;
    endtask

    initial begin
        logic [63:0] exp2[8];
        // Reset state with both sources requesting.
        nreset        = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 2'b11;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 2'b11;
        s_axis_tuser  = '0;
        #23;
        check("rst_tready", {62'b0, s_axis_tready}, 64'h0);
        check("rst_tvalid", {63'b0, m_axis_tvalid}, 64'h0);
        check("rst_tdata", m_axis_tdata, 64'h0);
        check("rst_grant", {63'b0, grant_o}, 64'h0);
        check("rst_abort", {63'b0, abort_o}, 64'h0);

        // Single 3-beat packet on ch0.
        do_reset();
        load(0, 0, 64'h11, 1'b0);
        load(0, 1, 64'h22, 1'b0);
        load(0, 2, 64'h33, 1'b1);
        sen[0] = 1'b1;
        cyc();
        check("t1_lat_valid", {63'b0, m_axis_tvalid}, 64'h1);
        check("t1_lat_data", m_axis_tdata, 64'h11);
        check("t1_grant", {63'b0, grant_o}, 64'h0);
        repeat (4) cyc();
        check("t1_count", od.size(), 3);
        check_beat("t1", 0, 64'h11, KLU_MID);
        check_beat("t1", 1, 64'h22, KLU_MID);
        check_beat("t1", 2, 64'h33, KLU_LAST);
        check("t1_first_cyc", (oc.size() > 0) ? oc[0] : -1, 1);
        check("t1_last_cyc", (oc.size() > 2) ? oc[2] : -1, 3);

        // Two streaming sources, round-robin alternation with no bubbles.
        do_reset();
        load(0, 0, 64'h01, 1'b0); load(0, 1, 64'h02, 1'b1);
        load(0, 2, 64'h03, 1'b0); load(0, 3, 64'h04, 1'b1);
        load(1, 0, 64'h81, 1'b0); load(1, 1, 64'h82, 1'b1);
        load(1, 2, 64'h83, 1'b0); load(1, 3, 64'h84, 1'b1);
        sen[0] = 1'b1;
        sen[1] = 1'b1;
        exp2 = '{64'h01, 64'h02, 64'h81, 64'h82, 64'h03, 64'h04, 64'h83, 64'h84};
        repeat (11) cyc();
        check("t2_count", od.size(), 8);
        for (int i = 0; i < 8; i++) check_beat("t2", i, exp2[i], (i % 2 == 1) ? KLU_LAST : KLU_MID);
        check("t2_nobubble", (oc.size() > 7) ? oc[7] - oc[0] : -1, 7);
        check("t2_tready_seq", {48'b0, rdy_hist[7], rdy_hist[6], rdy_hist[5], rdy_hist[4],
                                rdy_hist[3], rdy_hist[2], rdy_hist[1], rdy_hist[0]}, 64'hA5A5);
        check("fp_tready", {62'b0, fp_tready}, 64'h1);
        check("fp_data", fp_m_tdata, 64'h55);
        check("fp_grant", {63'b0, fp_grant}, 64'h0);

        // Downstream ready toggling 1010: every beat once, in order, held while stalled.
        do_reset();
        load(0, 0, 64'h11, 1'b0); load(0, 1, 64'h22, 1'b0);
        load(0, 2, 64'h33, 1'b0); load(0, 3, 64'h44, 1'b1);
        sen[0]        = 1'b1;
        mr_mode       = 1'b1;
        m_axis_tready = 1'b0;
        repeat (12) cyc();
        check("t4_count", od.size(), 4);
        check_beat("t4", 0, 64'h11, KLU_MID);
        check_beat("t4", 1, 64'h22, KLU_MID);
        check_beat("t4", 2, 64'h33, KLU_MID);
        check_beat("t4", 3, 64'h44, KLU_LAST);
        check("t4_hold", hold_err, 0);
        check("t4_stall_ready", {62'b0, rdy_hist[1]}, 64'h0);

        // Watchdog abort after 4 idle cycles, drain of ch0 tail, ch1 granted meanwhile.
        do_reset();
        load(0, 0, 64'h11, 1'b0); load(0, 1, 64'h22, 1'b0);
        load(0, 2, 64'h33, 1'b1); load(0, 3, 64'h44, 1'b1);
        load(1, 0, 64'hA1, 1'b0); load(1, 1, 64'hA2, 1'b1);
        sen[0] = 1'b1;
        sen[1] = 1'b1;
        cyc();
        sen[0] = 1'b0;
        repeat (3) cyc();
        check("t5_no_early_abort", {63'b0, abort_o}, 64'h0);
        cyc();
        check("t5_abort_pulse", {63'b0, abort_o}, 64'h1);
        check("t5_abort_beat", {m_axis_tdata[59:0], m_axis_tvalid, m_axis_tlast, m_axis_tuser, 1'b0},
              64'hE);
        check("t5_abort_keep", {56'b0, m_axis_tkeep}, 64'h0);
        sen[0] = 1'b1;
        repeat (8) cyc();
        check("t5_count", od.size(), 5);
        check_beat("t5", 0, 64'h11, KLU_MID);
        check_beat("t5", 1, 64'h00, KLU_ABORT);
        check_beat("t5", 2, 64'hA1, KLU_MID);
        check_beat("t5", 3, 64'hA2, KLU_LAST);
        check_beat("t5", 4, 64'h44, KLU_LAST);
        check("t5_abort_cnt", abort_cnt, 1);
        check("t5_lock_ready", {62'b0, rdy_hist[2]}, 64'h1);
        check("t5_drain_ready", {58'b0, rdy_hist[7], rdy_hist[6], rdy_hist[5]}, 64'h1F);

        // Asynchronous reset mid-packet, then a clean packet.
        do_reset();
        load(0, 0, 64'h51, 1'b0); load(0, 1, 64'h52, 1'b0); load(0, 2, 64'h53, 1'b1);
        sen[0] = 1'b1;
        cyc();
        s_axis_tvalid = 2'b01;
        #2;
        nreset = 1'b0;
        #1;
        check("t6_tvalid", {63'b0, m_axis_tvalid}, 64'h0);
        check("t6_tdata", m_axis_tdata, 64'h0);
        check("t6_tready", {62'b0, s_axis_tready}, 64'h0);
        check("t6_abort", {63'b0, abort_o}, 64'h0);
        do_reset();
        load(0, 0, 64'h71, 1'b0); load(0, 1, 64'h72, 1'b1);
        sen[0] = 1'b1;
        repeat (5) cyc();
        check("t6_count", od.size(), 2);
        check_beat("t6", 0, 64'h71, KLU_MID);
        check_beat("t6", 1, 64'h72, KLU_LAST);
        check("t6_abort_cnt", abort_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
